// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU core, the VIDAC blitter, the arbiter and the block-RAM port.
// Handshake: a master raises req and keeps it up until it sees ce=1; ce=1 in a cycle means the access completed and its read data is on *_i.
interface mem_arbiter_if;
  logic        cpu_req;
  logic [19:0] cpu_a;
  logic [7:0]  cpu_o;
  logic        cpu_w;
  logic [7:0]  cpu_i;
  logic        cpu_ce;
  logic        vid_req;
  logic [17:0] vid_a;
  logic [7:0]  vid_o;
  logic        vid_w;
  logic [7:0]  vid_i;
  logic        vid_ce;
  logic [19:0] mem_a;
  logic [7:0]  mem_o;
  logic        mem_w;
  logic [7:0]  mem_i;
  logic [1:0]  arb_state;

  modport slave (
    input  cpu_req, cpu_a, cpu_o, cpu_w,
    output cpu_i, cpu_ce,
    input  vid_req, vid_a, vid_o, vid_w,
    output vid_i, vid_ce,
    output mem_a, mem_o, mem_w,
    input  mem_i,
    output arb_state
  );

  modport master (
    output cpu_req, cpu_a, cpu_o, cpu_w,
    input  cpu_i, cpu_ce,
    output vid_req, vid_a, vid_o, vid_w,
    input  vid_i, vid_ce,
    input  mem_a, mem_o, mem_w,
    output mem_i,
    input  arb_state
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master (CPU / VIDAC) arbiter onto one synchronous byte-wide memory port.
// Every access is ADDR then DATA; the owner's ce pulses in DATA, the other master stays frozen.
module mem_arbiter #(
  parameter int unsigned CPU_SLOTS = 1,
  parameter logic [19:0] VID_BASE  = 20'hA0000
) (
  input  logic         clock,
  input  logic         reset,
  mem_arbiter_if.slave bus
);
  localparam logic [3:0] SLOTS = 4'(CPU_SLOTS);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

  state_t      state, state_nxt;
  logic        owner, owner_nxt;          // 1 = VIDAC owns the access
  logic [3:0]  cpu_cnt, cpu_cnt_nxt;
  logic [7:0]  cpu_hold, vid_hold;
  logic [19:0] addr_q;
  logic [7:0]  wdata_q;
  logic        grant_vid;
  logic [19:0] owner_addr;
  logic [7:0]  owner_wdata;
  logic        owner_w;

  assign bus.arb_state = state;

  // Contested grants go to the VIDAC only once the CPU has used its slots.
  always_comb begin
    grant_vid = 1'b0;
    if (bus.vid_req && !bus.cpu_req) grant_vid = 1'b1;
    else if (bus.vid_req && bus.cpu_req) grant_vid = (cpu_cnt >= SLOTS);
  end

  // VIDAC offsets relocate into the video window, wrapping at 1 MB.
  always_comb begin
    owner_addr  = owner ? (VID_BASE + {2'b00, bus.vid_a}) : bus.cpu_a;
    owner_wdata = owner ? bus.vid_o : bus.cpu_o;
    owner_w     = owner ? bus.vid_w : bus.cpu_w;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      owner   <= 1'b0;
      cpu_cnt <= 4'd0;
    end else begin
      state   <= state_nxt;
      owner   <= owner_nxt;
      cpu_cnt <= cpu_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    cpu_cnt_nxt = cpu_cnt;
    case (state)
      IDLE, DATA: begin
        if (bus.cpu_req || bus.vid_req) begin
          state_nxt   = ADDR;
          owner_nxt   = grant_vid;
          cpu_cnt_nxt = grant_vid ? 4'd0 : ((cpu_cnt == 4'd15) ? 4'd15 : cpu_cnt + 4'd1);
        end else begin
          state_nxt = IDLE;
        end
      end
      ADDR:    state_nxt = DATA;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q   <= 20'd0;
      wdata_q  <= 8'd0;
      cpu_hold <= 8'd0;
      vid_hold <= 8'd0;
    end else begin
      if (state == ADDR) begin
        addr_q  <= owner_addr;
        wdata_q <= owner_wdata;
      end
      if (state == DATA) begin
        if (owner) vid_hold <= bus.mem_i;
        else       cpu_hold <= bus.mem_i;
      end
    end
  end

  always_comb begin
    bus.mem_a  = 20'd0;
    bus.mem_o  = 8'd0;
    bus.mem_w  = 1'b0;
    bus.cpu_ce = 1'b0;
    bus.vid_ce = 1'b0;
    bus.cpu_i  = cpu_hold;
    bus.vid_i  = vid_hold;
    case (state)
      ADDR: begin
        bus.mem_a = owner_addr;
        bus.mem_o = owner_wdata;
        bus.mem_w = owner_w;
      end
      DATA: begin
        bus.mem_a = addr_q;
        bus.mem_o = wdata_q;
        if (owner) begin
          bus.vid_ce = 1'b1;
          bus.vid_i  = bus.mem_i;
        end else begin
          bus.cpu_ce = 1'b1;
          bus.cpu_i  = bus.mem_i;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (1 slot at base FFFF0, 3 slots at base A0000) share
// the same master stimulus; each has its own memory and an access-level reference model.
module tb_mem_arbiter;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        cpu_req, cpu_w, vid_req, vid_w;
  logic [19:0] cpu_a;
  logic [17:0] vid_a;
  logic [7:0]  cpu_o, vid_o, mi0, mi1;

  mem_arbiter_if if0 ();
  mem_arbiter_if if1 ();

  mem_arbiter #(.CPU_SLOTS(1), .VID_BASE(20'hFFFF0)) u0 (.clock(clock), .reset(reset), .bus(if0.slave));
  mem_arbiter #(.CPU_SLOTS(3), .VID_BASE(20'hA0000)) u1 (.clock(clock), .reset(reset), .bus(if1.slave));

  assign if0.cpu_req = cpu_req;  assign if1.cpu_req = cpu_req;
  assign if0.cpu_a   = cpu_a;    assign if1.cpu_a   = cpu_a;
  assign if0.cpu_o   = cpu_o;    assign if1.cpu_o   = cpu_o;
  assign if0.cpu_w   = cpu_w;    assign if1.cpu_w   = cpu_w;
  assign if0.vid_req = vid_req;  assign if1.vid_req = vid_req;
  assign if0.vid_a   = vid_a;    assign if1.vid_a   = vid_a;
  assign if0.vid_o   = vid_o;    assign if1.vid_o   = vid_o;
  assign if0.vid_w   = vid_w;    assign if1.vid_w   = vid_w;
  assign if0.mem_i   = mi0;      assign if1.mem_i   = mi1;

  logic [19:0] o_ma [2];
  logic [7:0]  o_mo [2], o_ci [2], o_vi [2];
  logic        o_mw [2], o_cc [2], o_vc [2];
  assign o_ma[0] = if0.mem_a;   assign o_ma[1] = if1.mem_a;
  assign o_mo[0] = if0.mem_o;   assign o_mo[1] = if1.mem_o;
  assign o_mw[0] = if0.mem_w;   assign o_mw[1] = if1.mem_w;
  assign o_ci[0] = if0.cpu_i;   assign o_ci[1] = if1.cpu_i;
  assign o_vi[0] = if0.vid_i;   assign o_vi[1] = if1.vid_i;
  assign o_cc[0] = if0.cpu_ce;  assign o_cc[1] = if1.cpu_ce;
  assign o_vc[0] = if0.vid_ce;  assign o_vc[1] = if1.vid_ce;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Environment memory and the model's own view of memory, keyed by instance and address.
  logic [7:0] pmem [int];
  logic [7:0] rmem [int];

  function automatic int key_of(input int k, input logic [19:0] a);
    return (k << 20) | int'({12'd0, a});
  endfunction

  function automatic logic [7:0] init_byte(input int k, input logic [19:0] a);
    return a[7:0] ^ a[15:8] ^ {4'(k), a[19:16]} ^ 8'h5A;
  endfunction

  function automatic logic [7:0] pread(input int k, input logic [19:0] a);
    if (pmem.exists(key_of(k, a))) return pmem[key_of(k, a)];
    return init_byte(k, a);
  endfunction

  function automatic logic [7:0] rread(input int k, input logic [19:0] a);
    if (rmem.exists(key_of(k, a))) return rmem[key_of(k, a)];
    return init_byte(k, a);
  endfunction

  // Reference model: an access is either in its first (address) or second (data) half.
  int          slots [2] = '{1, 3};
  logic [19:0] base  [2] = '{20'hFFFF0, 20'hA0000};
  bit          m_busy [2], m_second [2], m_vid [2];
  int          m_cnt [2];
  logic [7:0]  m_hc [2], m_hv [2], m_rd [2];
  logic [19:0] m_ad [2];
  logic [19:0] e_ma [2];
  logic [7:0]  e_mo [2];
  logic        e_mw [2];

  logic [0:0] exp_q0[$];
  logic [0:0] exp_q1[$];

  task automatic model_reset(input int k);
    m_busy[k] = 0; m_second[k] = 0; m_vid[k] = 0; m_cnt[k] = 0;
    m_hc[k] = 8'h00; m_hv[k] = 8'h00;
  endtask

  function automatic bit pick_vid(input int k);
    if (vid_req && !cpu_req) return 1;
    if (vid_req && cpu_req) return m_cnt[k] >= slots[k];
    return 0;
  endfunction

  task automatic compare_inst(input int k);
    logic [7:0] ci, vi;
    logic       cc, vc;
    e_ma[k] = 20'd0; e_mw[k] = 1'b0; e_mo[k] = 8'd0;
    ci = m_hc[k]; vi = m_hv[k]; cc = 1'b0; vc = 1'b0;
    if (m_busy[k] && !m_second[k]) begin
      e_ma[k] = m_vid[k] ? 20'(base[k] + {2'b00, vid_a}) : cpu_a;
      e_mw[k] = m_vid[k] ? vid_w : cpu_w;
      e_mo[k] = m_vid[k] ? vid_o : cpu_o;
    end else if (m_busy[k]) begin
      e_ma[k] = m_ad[k];
      if (m_vid[k]) begin vc = 1'b1; vi = m_rd[k]; end
      else begin cc = 1'b1; ci = m_rd[k]; end
    end
    check_eq($sformatf("u%0d.mem_a", k), 32'(o_ma[k]), 32'(e_ma[k]));
    check_eq($sformatf("u%0d.mem_w", k), 32'(o_mw[k]), 32'(e_mw[k]));
    if (e_mw[k]) check_eq($sformatf("u%0d.mem_o", k), 32'(o_mo[k]), 32'(e_mo[k]));
    check_eq($sformatf("u%0d.cpu_ce", k), 32'(o_cc[k]), 32'(cc));
    check_eq($sformatf("u%0d.vid_ce", k), 32'(o_vc[k]), 32'(vc));
    check_eq($sformatf("u%0d.cpu_i", k), 32'(o_ci[k]), 32'(ci));
    check_eq($sformatf("u%0d.vid_i", k), 32'(o_vi[k]), 32'(vi));
    check_eq($sformatf("u%0d.ce_overlap", k), 32'(o_cc[k] & o_vc[k]), 32'd0);
  endtask

  task automatic model_advance(input int k);
    bit gv;
    if (m_busy[k] && !m_second[k]) begin
      m_ad[k] = e_ma[k];
      m_rd[k] = rread(k, e_ma[k]);
      if (e_mw[k]) rmem[key_of(k, e_ma[k])] = e_mo[k];
      m_second[k] = 1;
    end else begin
      if (m_busy[k]) begin
        if (m_vid[k]) m_hv[k] = m_rd[k];
        else          m_hc[k] = m_rd[k];
      end
      if (cpu_req || vid_req) begin
        gv = pick_vid(k);
        m_vid[k] = gv;
        m_cnt[k] = gv ? 0 : ((m_cnt[k] >= 15) ? 15 : m_cnt[k] + 1);
        m_busy[k] = 1; m_second[k] = 0;
      end else begin
        m_busy[k] = 0;
      end
    end
  endtask

  // One clock: inputs were set at the negedge; compare, play memory, advance model.
  task automatic step();
    logic [7:0] nxt [2];
    logic [0:0] e;
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) if (reset) model_reset(k);
    for (int k = 0; k < 2; k++) compare_inst(k);
    if (exp_q0.size() > 0 && (o_cc[0] || o_vc[0])) begin
      e = exp_q0.pop_front();
      check_eq("order_u0", 32'(o_vc[0]), 32'(e));
    end
    if (exp_q1.size() > 0 && (o_cc[1] || o_vc[1])) begin
      e = exp_q1.pop_front();
      check_eq("order_u1", 32'(o_vc[1]), 32'(e));
    end
    for (int k = 0; k < 2; k++) begin
      nxt[k] = pread(k, o_ma[k]);
      if (o_mw[k]) pmem[key_of(k, o_ma[k])] = o_mo[k];
    end
    if (!reset) for (int k = 0; k < 2; k++) model_advance(k);
    @(posedge clock);
    #1;
    mi0 = nxt[0];
    mi1 = nxt[1];
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_w = 0; cpu_a = 20'd0; cpu_o = 8'd0;
    vid_req = 0; vid_w = 0; vid_a = 18'd0; vid_o = 8'd0;
  endtask

  task automatic pulse_reset();
    reset = 1; step();
    reset = 0;
  endtask

  initial begin
    reset = 1; mi0 = 8'd0; mi1 = 8'd0;
    idle_inputs();
    @(negedge clock);
    step(); step();
    reset = 0;

    // Preload EA at FFFF0 and EF at 00002 through CPU writes.
    cpu_req = 1; cpu_w = 1; cpu_a = 20'hFFFF0; cpu_o = 8'hEA;
    step(); step();
    cpu_a = 20'h00002; cpu_o = 8'hEF;
    step(); step();
    cpu_req = 0; cpu_w = 0;
    step(); step();

    // CPU-only reads of FFFF0 straight out of reset.
    pulse_reset();
    cpu_req = 1; cpu_a = 20'hFFFF0;
    repeat (8) step();

    // VIDAC-only write at offset 10.
    idle_inputs(); pulse_reset();
    vid_req = 1; vid_a = 18'h00010; vid_w = 1; vid_o = 8'hAA;
    step(); step();
    vid_req = 0; vid_w = 0;
    step(); step();
    check_eq("vid_wr_u1", 32'(pread(1, 20'hA0010)), 32'h0000_00AA);
    check_eq("vid_wr_u0", 32'(pread(0, 20'h00000)), 32'h0000_00AA);

    // Continuous contention from a fresh reset: grant order per slot count.
    idle_inputs(); pulse_reset();
    for (int i = 0; i < 8; i++) begin
      exp_q0.push_back(1'((i % 2) == 1));
      exp_q1.push_back(1'((i % 4) == 3));
    end
    cpu_req = 1; vid_req = 1;
    for (int i = 0; i < 18; i++) begin
      cpu_a = 20'($urandom_range(0, 15));
      vid_a = 18'($urandom_range(0, 15));
      step();
    end
    check_eq("order_u0_left", 32'(exp_q0.size()), 32'd0);
    check_eq("order_u1_left", 32'(exp_q1.size()), 32'd0);

    // Relocation wraps modulo 1 MB.
    idle_inputs(); pulse_reset();
    vid_req = 1; vid_a = 18'h3FFFF;
    step();
    #1 check_eq("wrap_u0", 32'(o_ma[0]), 32'h0003_FFEF);
    step(); step(); step();

    // Reset during the address cycle of a VIDAC write.
    idle_inputs(); pulse_reset();
    vid_req = 1; vid_w = 1; vid_a = 18'h00020; vid_o = 8'h77;
    step();
    reset = 1;
    #1 check_eq("rst_mem_w_u1", 32'(o_mw[1]), 32'd0);
    step(); step();
    reset = 0; vid_req = 0; vid_w = 0;
    step();
    check_eq("cut_write_u1", 32'(pread(1, 20'hA0020)), 32'(rread(1, 20'hA0020)));
    cpu_req = 1; vid_req = 1;
    repeat (6) step();

    // CPU read of 00002, then a VIDAC-only run: cpu_i must hold EF.
    idle_inputs(); pulse_reset();
    cpu_req = 1; cpu_a = 20'h00002;
    step();
    cpu_req = 0; vid_req = 1;
    step();
    for (int i = 0; i < 21; i++) begin
      vid_a = 18'($urandom_range(0, 15));
      vid_w = 1'($urandom_range(0, 1));
      vid_o = 8'($urandom_range(0, 255));
      step();
      check_eq("cpu_i_u0_hold", 32'(o_ci[0]), 32'h0000_00EF);
      check_eq("cpu_i_u1_hold", 32'(o_ci[1]), 32'h0000_00EF);
    end

    // Randomized traffic with occasional asynchronous resets.
    idle_inputs();
    for (int i = 0; i < 3000; i++) begin
      if (reset) reset = 0;
      else if ($urandom_range(0, 99) == 0) reset = 1;
      cpu_req = ($urandom_range(0, 3) != 0);
      vid_req = ($urandom_range(0, 2) != 0);
      cpu_a = $urandom_range(0, 1) ? 20'($urandom_range(0, 15)) : 20'hFFFF0 + 20'($urandom_range(0, 15));
      vid_a = $urandom_range(0, 1) ? 18'($urandom_range(0, 15)) : 18'h3FFF0 + 18'($urandom_range(0, 15));
      cpu_w = ($urandom_range(0, 3) == 0);
      vid_w = ($urandom_range(0, 2) == 0);
      cpu_o = 8'($urandom_range(0, 255));
      vid_o = 8'($urandom_range(0, 255));
      step();
    end
    reset = 0; idle_inputs();
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
